// File: rtl/pio_out_pulse_if.sv
// Avalon-MM slave bus bundle for pio_out_pulse: word address, select,
// active-low write strobe, write data and combinational read data.
interface pio_out_pulse_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   // Bus master drives the request and samples read data.
   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   // Peripheral side: consumes the request, returns read data.
   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/pio_out_pulse.sv
// Parallel output port with a self-timed pulse generator.
// Software writes a DATA register that drives out_port; a PULSE write
// inverts the masked bits for PULSE_LEN+1 cycles, after which they
// return to DATA. STATUS reports busy, a sticky error flag (pulse
// requested while one is running) and the live down-counter.
module pio_out_pulse #(
   parameter int unsigned             WIDTH             = 1,
   parameter logic [WIDTH-1:0]        RESET_VALUE       = '0,
   parameter int unsigned             CNT_WIDTH         = 16,
   parameter logic [CNT_WIDTH-1:0]    DEFAULT_PULSE_LEN = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   pio_out_pulse_if.slave        bus,
   output logic [WIDTH-1:0]      out_port
);

   // Register word addresses.
   typedef enum logic [2:0] {
      A_DATA     = 3'd0,
      A_PLEN     = 3'd1,
      A_PULSE    = 3'd2,
      A_STATUS   = 3'd3,
      A_OUTSET   = 3'd4,
      A_OUTCLEAR = 3'd5,
      A_RSVD6    = 3'd6,
      A_RSVD7    = 3'd7
   } addr_e;

   // Pulse generator states.
   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   state_e                 state_q, state_d;
   logic [WIDTH-1:0]       data_q, data_d;
   logic [WIDTH-1:0]       pmask_q, pmask_d;
   logic [CNT_WIDTH-1:0]   plen_q, plen_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   err_q, err_d;

   logic                   wr;
   logic [WIDTH-1:0]       wmask;
   logic                   pulse_wr;
   logic                   err_set;
   logic [63:0]            status_wide;
   logic                   unused_wd;

   // Decoded bus write strobe and the register-width slice of writedata.
   assign wr        = bus.chipselect & ~bus.write_n;
   assign wmask     = bus.writedata[WIDTH-1:0];
   assign pulse_wr  = wr && (bus.address == A_PULSE);
   assign unused_wd = ^bus.writedata;

   // DATA register next value: direct write, bit-set and bit-clear forms.
   always_comb begin
      data_d = data_q;
      if (wr) begin
         case (bus.address)
            A_DATA:     data_d = wmask;
            A_OUTSET:   data_d = data_q | wmask;
            A_OUTCLEAR: data_d = data_q & ~wmask;
            default:    data_d = data_q;
         endcase
      end
   end

   // PULSE_LEN register; a running pulse keeps its own copy in cnt_q.
   always_comb begin
      plen_d = plen_q;
      if (wr && (bus.address == A_PLEN)) begin
         plen_d = bus.writedata[CNT_WIDTH-1:0];
      end
   end

   // Pulse FSM: next state, counter, mask, and error-set request.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pmask_d = pmask_q;
      err_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (pulse_wr && (wmask != '0)) begin
               state_d = ACTIVE;
               pmask_d = wmask;
               cnt_d   = plen_q;
            end
         end
         ACTIVE: begin
            // A trigger while running (even on the expiry cycle) is
            // rejected and flagged; the current pulse is unaffected.
            if (pulse_wr) begin
               err_set = 1'b1;
            end
            if (cnt_q == '0) begin
               state_d = IDLE;
               pmask_d = '0;
            end else begin
               cnt_d = cnt_q - CNT_WIDTH'(1);
            end
         end
         default: begin
            state_d = IDLE;
            pmask_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Sticky error flag: write-1-to-clear, with a coincident set winning.
   always_comb begin
      err_d = err_q;
      if (err_set) begin
         err_d = 1'b1;
      end else if (wr && (bus.address == A_STATUS) && bus.writedata[1]) begin
         err_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset; bus writes in a
   // reset cycle are dropped because the reset branch takes priority.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         data_q  <= RESET_VALUE;
         pmask_q <= '0;
         plen_q  <= DEFAULT_PULSE_LEN;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         pmask_q <= pmask_d;
         plen_q  <= plen_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Pins are a pure function of registers: DATA with pulsed bits inverted.
   assign out_port = data_q ^ pmask_q;

   // STATUS image built wide so cnt can sit at bit 8 for any CNT_WIDTH,
   // then truncated to the 32-bit bus.
   always_comb begin
      status_wide    = '0;
      status_wide[0] = (state_q == ACTIVE);
      status_wide[1] = err_q;
      if (state_q == ACTIVE) begin
         status_wide[CNT_WIDTH+7:8] = cnt_q;
      end
   end

   // Zero-latency read mux; unused upper bits and write-only or reserved
   // addresses read as zero. Stays live during reset.
   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         A_DATA:   bus.readdata[WIDTH-1:0]     = data_q;
         A_PLEN:   bus.readdata[CNT_WIDTH-1:0] = plen_q;
         A_STATUS: bus.readdata                = status_wide[31:0];
         default:  bus.readdata                = '0;
      endcase
   end

endmodule

// File: tb/tb_pio_out_pulse.sv
// Directed bench for pio_out_pulse (WIDTH=8, RESET_VALUE=8'hA5,
// DEFAULT_PULSE_LEN=5): a register-map vector table plus hand-written
// pulse sequences for timing, error, mid-pulse update and reset abort.
module tb_pio_out_pulse;

   localparam int unsigned W   = 8;
   localparam logic [7:0]  RV  = 8'hA5;
   localparam int unsigned CW  = 16;
   localparam logic [15:0] DPL = 16'd5;

   logic          clk;
   logic          reset_n;
   logic [W-1:0]  out_port;

   pio_out_pulse_if bus();

   pio_out_pulse #(
      .WIDTH             (W),
      .RESET_VALUE       (RV),
      .CNT_WIDTH         (CW),
      .DEFAULT_PULSE_LEN (DPL)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .out_port (out_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_bad;

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [7:0]  exp_out;
      logic [2:0]  rd_addr;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // One bus write, applied at the next rising edge; returns #1 after it.
   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(posedge clk);
      #1;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      bus.address = a;
      #1;
      d = bus.readdata;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] rd;

   initial begin
      n_cmp = 0;
      n_bad = 0;

      // addr, wdata, expected out_port, readback addr, expected readback
      vecs[0]  = '{3'd0, 32'h0000_000F, 8'h0F, 3'd0, 32'h0000_000F};
      vecs[1]  = '{3'd4, 32'h0000_00F0, 8'hFF, 3'd0, 32'h0000_00FF};
      vecs[2]  = '{3'd5, 32'h0000_0003, 8'hFC, 3'd0, 32'h0000_00FC};
      vecs[3]  = '{3'd0, 32'hFFFF_FF3C, 8'h3C, 3'd0, 32'h0000_003C};
      vecs[4]  = '{3'd1, 32'h1234_5678, 8'h3C, 3'd1, 32'h0000_5678};
      vecs[5]  = '{3'd6, 32'h0000_00FF, 8'h3C, 3'd6, 32'h0000_0000};
      vecs[6]  = '{3'd7, 32'h0000_00FF, 8'h3C, 3'd7, 32'h0000_0000};
      vecs[7]  = '{3'd3, 32'h0000_0003, 8'h3C, 3'd3, 32'h0000_0000};
      vecs[8]  = '{3'd2, 32'h0000_0000, 8'h3C, 3'd3, 32'h0000_0000};
      vecs[9]  = '{3'd4, 32'h0000_0000, 8'h3C, 3'd4, 32'h0000_0000};
      vecs[10] = '{3'd5, 32'h0000_0000, 8'h3C, 3'd5, 32'h0000_0000};
      vecs[11] = '{3'd1, 32'h0000_0003, 8'h3C, 3'd2, 32'h0000_0000};

      bus.address    = 3'd0;
      bus.writedata  = '0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      reset_n        = 1'b0;
      repeat (3) idle_cycle();
      reset_n = 1'b1;

      // Reset state
      check("rst_out", {24'h0, out_port}, {24'h0, RV});
      bus_read(3'd0, rd); check("rst_data", rd, 32'h0000_00A5);
      bus_read(3'd1, rd); check("rst_plen", rd, {16'h0, DPL});
      bus_read(3'd3, rd); check("rst_status", rd, 32'h0);

      // Register map, back-to-back writes
      for (int i = 0; i < 12; i++) begin
         bus_write(vecs[i].addr, vecs[i].wdata);
         check($sformatf("vec%0d_out", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
         bus_read(vecs[i].rd_addr, rd);
         check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      end

      // PULSE_LEN=3 pulse on bit 0: exactly 4 cycles, cnt 3,2,1,0
      bus_write(3'd0, 32'h0);
      bus_write(3'd2, 32'h01);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("p3_out%0d", i), {24'h0, out_port}, 32'h01);
         bus_read(3'd3, rd);
         check($sformatf("p3_stat%0d", i), rd, ((32'd3 - 32'(i)) << 8) | 32'h1);
         idle_cycle();
      end
      check("p3_out_end", {24'h0, out_port}, 32'h00);
      bus_read(3'd3, rd); check("p3_stat_end", rd, 32'h0);

      // PULSE_LEN=0: 1-cycle pulse; trigger on its expiry cycle -> err
      bus_write(3'd1, 32'h0);
      bus_write(3'd2, 32'h80);
      check("p0_out", {24'h0, out_port}, 32'h80);
      bus_read(3'd3, rd); check("p0_stat", rd, 32'h1);
      bus_write(3'd2, 32'h01);
      check("p0_out_after", {24'h0, out_port}, 32'h00);
      bus_read(3'd3, rd); check("p0_err", rd, 32'h2);
      idle_cycle();
      check("p0_no_retrig", {24'h0, out_port}, 32'h00);
      bus_write(3'd3, 32'h1);
      bus_read(3'd3, rd); check("err_w1_bit0_keeps", rd, 32'h2);
      bus_write(3'd3, 32'h2);
      bus_read(3'd3, rd); check("err_clear", rd, 32'h0);

      // PULSE_LEN=10 with DATA write and PULSE_LEN write mid-pulse
      bus_write(3'd1, 32'd10);
      bus_write(3'd2, 32'h01);
      check("p10_start", {24'h0, out_port}, 32'h01);
      bus_write(3'd0, 32'h01);
      check("p10_data_mid", {24'h0, out_port}, 32'h00);
      bus_write(3'd1, 32'd2);
      bus_read(3'd3, rd); check("p10_cnt8", rd, 32'h0000_0801);
      repeat (8) idle_cycle();
      check("p10_last_out", {24'h0, out_port}, 32'h00);
      bus_read(3'd3, rd); check("p10_last_stat", rd, 32'h1);
      idle_cycle();
      check("p10_expired", {24'h0, out_port}, 32'h01);
      bus_read(3'd3, rd); check("p10_idle_stat", rd, 32'h0);
      bus_read(3'd1, rd); check("p10_plen_next", rd, 32'd2);

      // PULSE_LEN=100, error raised, then reset mid-pulse with a write
      bus_write(3'd1, 32'd100);
      bus_write(3'd2, 32'h02);
      check("p100_out", {24'h0, out_port}, 32'h03);
      bus_write(3'd2, 32'h04);
      bus_read(3'd3, rd); check("p100_busy_err", rd, 32'h0000_6303);
      check("p100_out_kept", {24'h0, out_port}, 32'h03);
      bus.address    = 3'd0;
      bus.writedata  = 32'h77;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      reset_n        = 1'b0;
      #1;
      check("rst_read_live", bus.readdata, 32'h01);
      @(posedge clk);
      #1;
      reset_n        = 1'b1;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      check("abort_out", {24'h0, out_port}, {24'h0, RV});
      bus_read(3'd0, rd); check("abort_data", rd, 32'h0000_00A5);
      bus_read(3'd3, rd); check("abort_status", rd, 32'h0);
      bus_read(3'd1, rd); check("abort_plen", rd, {16'h0, DPL});
      idle_cycle();
      check("abort_out_stable", {24'h0, out_port}, {24'h0, RV});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
